// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: branch condition codes, FSM state
// encoding, default widths and the branch-condition evaluator.
package pc_sequencer_pkg;

   localparam int DEFAULT_AW        = 9;
   localparam int DEFAULT_RAS_DEPTH = 4;

   localparam logic [2:0] COND_B   = 3'b000;
   localparam logic [2:0] COND_BEQ = 3'b001;
   localparam logic [2:0] COND_BNE = 3'b010;
   localparam logic [2:0] COND_BLT = 3'b011;
   localparam logic [2:0] COND_BLE = 3'b100;
   localparam logic [2:0] COND_BL  = 3'b101;
   localparam logic [2:0] COND_BX  = 3'b110;
   localparam logic [2:0] COND_BLX = 3'b111;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Unconditional codes (B, BL, BX, BLX) always report taken.
   function automatic logic cond_taken(input logic [2:0] cond,
                                       input logic z, input logic n, input logic v);
      logic res;
      res = 1'b1;
      case (cond)
         COND_BEQ: res = z;
         COND_BNE: res = ~z;
         COND_BLT: res = n ^ v;
         COND_BLE: res = (n ^ v) | z;
         default:  res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer (slave) and its driver
// (master, typically the instruction decode or a testbench).
interface pc_sequencer_if #(
   parameter int AW = 9
);
   logic          load_pc;
   logic          reset_pc;
   logic          br_en;
   logic [2:0]    cond;
   logic [AW-1:0] sximm;
   logic [AW-1:0] target;
   logic          Z;
   logic          N;
   logic          V;
   logic          halt;
   logic [AW-1:0] pc;
   logic [AW-1:0] link_out;
   logic          taken;
   logic          halted;
   logic          ras_full;
   logic          ras_empty;
   logic          ras_err;

   modport master (
      output load_pc, reset_pc, br_en, cond, sximm, target, Z, N, V, halt,
      input  pc, link_out, taken, halted, ras_full, ras_empty, ras_err
   );

   modport slave (
      input  load_pc, reset_pc, br_en, cond, sximm, target, Z, N, V, halt,
      output pc, link_out, taken, halted, ras_full, ras_empty, ras_err
   );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Return-address stack as a circular buffer; a push when full overwrites the
// oldest entry and flags a sticky error, as does a pop when empty.
module pc_ras #(
   parameter int AW    = 9,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          i_clear,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_data,
   output logic [AW-1:0] o_top,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_err
);
   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW:0]   r_cnt;
   logic          r_err;
   logic [PW-1:0] w_top_idx;
   logic          w_full;
   logic          w_empty;

   assign w_top_idx = r_wr - PW'(1);
   assign w_full    = (r_cnt == (PW+1)'(DEPTH));
   assign w_empty   = (r_cnt == '0);

   // When full, the write slot already holds the oldest entry.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_wr  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_clear) begin
         r_wr  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_push) begin
         r_wr <= r_wr + PW'(1);
         if (w_full) r_err <= 1'b1;
         else        r_cnt <= r_cnt + (PW+1)'(1);
      end else if (i_pop) begin
         if (w_empty) begin
            r_err <= 1'b1;
         end else begin
            r_wr  <= w_top_idx;
            r_cnt <= r_cnt - (PW+1)'(1);
         end
      end
   end

   assign o_top   = r_mem[w_top_idx];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_err   = r_err;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with RUN/HALT control; define PC_SEQ_RAS_EN to
// build in the return-address stack used by BL/BLX/BX.
//   state   | meaning
//   ST_RUN  | pc advances on load_pc
//   ST_HALT | pc/taken/stack frozen until reset_pc or reset
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int            AW        = DEFAULT_AW,
   parameter int            RAS_DEPTH = DEFAULT_RAS_DEPTH,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RAS_DEPTH must be a power of two and at least 2");
   end

   logic [0:0]    r_state;
   logic [AW-1:0] r_pc;
   logic          r_taken;
   logic [AW-1:0] w_link;
   logic [AW-1:0] w_br_tgt;
   logic [AW-1:0] w_next_pc;
   logic          w_next_taken;
   logic [AW-1:0] w_ras_top;
   logic          w_ras_full;
   logic          w_ras_empty;
   logic          w_ras_err;

   assign w_link   = r_pc + AW'(1);
   assign w_br_tgt = w_link + bus.sximm;

`ifdef PC_SEQ_RAS_EN
   logic w_upd;
   logic w_push;
   logic w_pop;

   assign w_upd  = (r_state == ST_RUN) && bus.load_pc && !bus.halt && !bus.reset_pc;
   assign w_push = w_upd && bus.br_en && (bus.cond == COND_BL || bus.cond == COND_BLX);
   // BX on an empty stack still pops so the stack flags the error itself.
   assign w_pop  = w_upd && bus.br_en && (bus.cond == COND_BX);

   pc_ras #(
      .AW    (AW),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_b   (reset),
      .i_clear (bus.reset_pc),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_link),
      .o_top   (w_ras_top),
      .o_full  (w_ras_full),
      .o_empty (w_ras_empty),
      .o_err   (w_ras_err)
   );
`else
   assign w_ras_top   = bus.target;
   assign w_ras_full  = 1'b0;
   assign w_ras_empty = 1'b1;
   assign w_ras_err   = 1'b0;
`endif

   always_comb begin
      w_next_pc    = w_link;
      w_next_taken = 1'b0;
      if (bus.br_en) begin
         w_next_taken = cond_taken(bus.cond, bus.Z, bus.N, bus.V);
         case (bus.cond)
            COND_BX:  w_next_pc = w_ras_empty ? bus.target : w_ras_top;
            COND_BLX: w_next_pc = bus.target;
            default:  w_next_pc = w_next_taken ? w_br_tgt : w_link;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VEC;
         r_taken <= 1'b0;
      end else if (bus.reset_pc) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VEC;
         r_taken <= 1'b0;
      end else if (r_state == ST_RUN && bus.load_pc) begin
         if (bus.halt) begin
            r_state <= ST_HALT;
         end else begin
            r_pc    <= w_next_pc;
            r_taken <= w_next_taken;
         end
      end
   end

   assign bus.pc        = r_pc;
   assign bus.link_out  = w_link;
   assign bus.taken     = r_taken;
   assign bus.halted    = (r_state == ST_HALT);
   assign bus.ras_full  = w_ras_full;
   assign bus.ras_empty = w_ras_empty;
   assign bus.ras_err   = w_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (AW=9, RAS_DEPTH=4, RESET_VEC=0);
// expectations follow PC_SEQ_RAS_EN when it is defined for the build.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   typedef struct {
      string      nm;
      logic       rp;
      logic       lp;
      logic       br;
      logic [2:0] cd;
      logic [8:0] sx;
      logic [8:0] tg;
      logic       z;
      logic       n;
      logic       v;
      logic       h;
      logic [8:0] epc;
      logic       et;
      logic       eh;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;
   vec_t vt [24];

   pc_sequencer_if #(.AW(9)) bus ();

   pc_sequencer #(
      .AW        (9),
      .RAS_DEPTH (4),
      .RESET_VEC (9'd0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string nm, logic rp, logic lp, logic br, logic [2:0] cd,
                               logic [8:0] sx, logic [8:0] tg, logic z, logic n, logic v,
                               logic h, logic [8:0] epc, logic et, logic eh);
      vec_t x;
      x.nm = nm; x.rp = rp; x.lp = lp; x.br = br; x.cd = cd; x.sx = sx; x.tg = tg;
      x.z = z; x.n = n; x.v = v; x.h = h; x.epc = epc; x.et = et; x.eh = eh;
      return x;
   endfunction

   task automatic apply(input vec_t x);
      bus.reset_pc = x.rp;
      bus.load_pc  = x.lp;
      bus.br_en    = x.br;
      bus.cond     = x.cd;
      bus.sximm    = x.sx;
      bus.target   = x.tg;
      bus.Z        = x.z;
      bus.N        = x.n;
      bus.V        = x.v;
      bus.halt     = x.h;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one operation, clock it, check pc and taken.
   task automatic step(input string nm, input logic rp, input logic lp, input logic br,
                       input logic [2:0] cd, input logic [8:0] sx, input logic [8:0] tg,
                       input logic h, input logic [8:0] epc, input logic et);
      apply(mk(nm, rp, lp, br, cd, sx, tg, 1'b0, 1'b0, 1'b0, h, epc, et, 1'b0));
      tick();
      chk({nm, ".pc"}, 32'(bus.pc), 32'(epc));
      chk({nm, ".taken"}, 32'(bus.taken), 32'(et));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0]  = mk("seq1",     0,1,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd1,  0,0);
      vt[1]  = mk("seq2",     0,1,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd2,  0,0);
      vt[2]  = mk("seq3",     0,1,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd3,  0,0);
      vt[3]  = mk("rpc_a",    1,0,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd0,  0,0);
      vt[4]  = mk("b_to5",    0,1,1,3'd0,9'd4,  9'd0,  0,0,0,0, 9'd5,  1,0);
      vt[5]  = mk("beq_t",    0,1,1,3'd1,9'h1FE,9'd0,  1,0,0,0, 9'd4,  1,0);
      vt[6]  = mk("rpc_b",    1,1,0,3'd0,9'd0,  9'd0,  0,0,0,1, 9'd0,  0,0);
      vt[7]  = mk("b_to5b",   0,1,1,3'd0,9'd4,  9'd0,  0,0,0,0, 9'd5,  1,0);
      vt[8]  = mk("beq_nt",   0,1,1,3'd1,9'h1FE,9'd0,  0,0,0,0, 9'd6,  0,0);
      vt[9]  = mk("hold",     0,0,1,3'd0,9'd7,  9'd0,  0,0,0,0, 9'd6,  0,0);
      vt[10] = mk("bne_t",    0,1,1,3'd2,9'd2,  9'd0,  0,0,0,0, 9'd9,  1,0);
      vt[11] = mk("blt_t",    0,1,1,3'd3,9'd0,  9'd0,  0,1,0,0, 9'd10, 1,0);
      vt[12] = mk("blt_nt",   0,1,1,3'd3,9'd5,  9'd0,  0,1,1,0, 9'd11, 0,0);
      vt[13] = mk("ble_t",    0,1,1,3'd4,9'd1,  9'd0,  1,0,0,0, 9'd13, 1,0);
      vt[14] = mk("ble_nt",   0,1,1,3'd4,9'd1,  9'd0,  0,0,0,0, 9'd14, 0,0);
      vt[15] = mk("blx",      0,1,1,3'd7,9'd3,  9'h1FF,0,0,0,0, 9'h1FF,1,0);
      vt[16] = mk("wrap_seq", 0,1,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd0,  0,0);
      vt[17] = mk("rpc_c",    1,0,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd0,  0,0);
      vt[18] = mk("b_neg",    0,1,1,3'd0,9'h1FD,9'd0,  0,0,0,0, 9'h1FE,1,0);
      vt[19] = mk("b_wrap",   0,1,1,3'd0,9'd3,  9'd0,  0,0,0,0, 9'd2,  1,0);
      vt[20] = mk("rpc_d",    1,0,0,3'd0,9'd0,  9'd0,  0,0,0,0, 9'd0,  0,0);
      vt[21] = mk("b_to10",   0,1,1,3'd0,9'd9,  9'd0,  0,0,0,0, 9'd10, 1,0);
      vt[22] = mk("bl",       0,1,1,3'd5,9'd20, 9'd0,  0,0,0,0, 9'd31, 1,0);
      vt[23] = mk("bx_ret",   0,1,1,3'd6,9'd0,  9'd100,0,0,0,0, RAS_ON ? 9'd11 : 9'd100, 1,0);

      apply(mk("idle", 0,0,0,3'd0,9'd0,9'd0,0,0,0,0,9'd0,0,0));
      #12;
      chk("rst.pc",        32'(bus.pc), 32'd0);
      chk("rst.taken",     32'(bus.taken), 32'd0);
      chk("rst.halted",    32'(bus.halted), 32'd0);
      chk("rst.ras_empty", 32'(bus.ras_empty), 32'd1);
      chk("rst.ras_full",  32'(bus.ras_full), 32'd0);
      chk("rst.ras_err",   32'(bus.ras_err), 32'd0);
      chk("rst.link_out",  32'(bus.link_out), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 24; i++) begin
         apply(vt[i]);
         tick();
         chk({vt[i].nm, ".pc"},     32'(bus.pc), 32'(vt[i].epc));
         chk({vt[i].nm, ".taken"},  32'(bus.taken), 32'(vt[i].et));
         chk({vt[i].nm, ".halted"}, 32'(bus.halted), 32'(vt[i].eh));
         chk({vt[i].nm, ".link"},   32'(bus.link_out), 32'((vt[i].epc + 9'd1) & 9'h1FF));
      end

      // Stack overflow, unwinding and underflow.
      step("rpc_e", 1,0,0,3'd0,9'd0,9'd0,0, 9'd0,0);
      for (int i = 1; i <= 5; i++) begin
         step("bl_chain", 0,1,1,3'd5,9'd0,9'd0,0, 9'(i),1);
         if (i == 4) begin
            chk("bl4.ras_full", 32'(bus.ras_full), 32'(RAS_ON));
            chk("bl4.ras_err",  32'(bus.ras_err), 32'd0);
         end
      end
      chk("bl5.ras_full",  32'(bus.ras_full), 32'(RAS_ON));
      chk("bl5.ras_err",   32'(bus.ras_err), 32'(RAS_ON));
      chk("bl5.ras_empty", 32'(bus.ras_empty), 32'(!RAS_ON));
      for (int i = 0; i < 4; i++)
         step("bx_pop", 0,1,1,3'd6,9'd0,9'd50,0, RAS_ON ? 9'(5 - i) : 9'd50,1);
      chk("bx4.ras_full", 32'(bus.ras_full), 32'd0);
      step("bx_under", 0,1,1,3'd6,9'd0,9'd50,0, 9'd50,1);
      chk("bx5.ras_empty", 32'(bus.ras_empty), 32'd1);
      chk("bx5.ras_err",   32'(bus.ras_err), 32'(RAS_ON));

      // Halt freezes everything until reset_pc.
      step("bl_to6", 0,1,1,3'd5,9'h1D3,9'd0,0, 9'd6,1);
      step("seq_to7", 0,1,0,3'd0,9'd0,9'd0,0, 9'd7,0);
      step("halt", 0,1,0,3'd0,9'd0,9'd0,1, 9'd7,0);
      chk("halt.halted",    32'(bus.halted), 32'd1);
      chk("halt.ras_empty", 32'(bus.ras_empty), 32'(!RAS_ON));
      step("halted_b1", 0,1,1,3'd0,9'd10,9'd0,0, 9'd7,0);
      step("halted_b2", 0,1,1,3'd5,9'd10,9'd0,0, 9'd7,0);
      chk("halted.halted",    32'(bus.halted), 32'd1);
      chk("halted.ras_empty", 32'(bus.ras_empty), 32'(!RAS_ON));
      step("rpc_halt", 1,1,0,3'd0,9'd0,9'd0,1, 9'd0,0);
      chk("rpc_halt.halted",    32'(bus.halted), 32'd0);
      chk("rpc_halt.ras_empty", 32'(bus.ras_empty), 32'd1);
      chk("rpc_halt.ras_err",   32'(bus.ras_err), 32'd0);
      step("run_again", 0,1,0,3'd0,9'd0,9'd0,0, 9'd1,0);

      // Async reset in the middle of a pending branch.
      step("b_to5c", 0,1,1,3'd0,9'd3,9'd0,0, 9'd5,1);
      apply(mk("b_pend", 0,1,1,3'd0,9'd20,9'd0,0,0,0,0,9'd0,0,0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("arst.pc",    32'(bus.pc), 32'd0);
      chk("arst.taken", 32'(bus.taken), 32'd0);
      tick();
      chk("arst_hold.pc", 32'(bus.pc), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step("post_arst", 0,1,0,3'd0,9'd0,9'd0,0, 9'd1,0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
